pairing_host_ctrl: RTL
======================

Name: pairing_host_ctrl

Overview:
- Run controller between a 32-bit host bus and the microcoded GF(3^m) pairing core.
- Loads operand words into the core's operand RAM via the shared port B.
- Holds the core's microcode sequencer in reset, releases it on start, and detects completion.
- Returns result words to the host beat by beat, arbitrating port B between host and core with no overlap.

Parameters:
DATA_W, 194, RAM word width (one field element, 2 bits per trit)
ADDR_W, 6, RAM address width
HOST_W, 32, host data beat width
BEATS, 7, beats per word; must equal ceil(DATA_W/HOST_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
host_valid  in  1  host beat valid
host_ready  out  1  beat accepted when valid && ready
host_we  in  1  1=write transaction, 0=read; sampled on first beat only
host_addr  in  ADDR_W  word address; sampled on first beat only
host_wdata  in  HOST_W  write beat data
host_rvalid  out  1  read beat valid
host_rdata  out  HOST_W  read beat data
host_start  in  1  start-run pulse
busy  out  1  core running
done_flag  out  1  sticky run-complete flag
core_reset  out  1  reset to core sequencer
core_done  in  1  core done (registered in core)
ram_sel  out  1  1=host owns RAM port B, 0=core owns it
ram_addr  out  ADDR_W  host-side port B address
ram_wdata  out  DATA_W  host-side port B write data
ram_w  out  1  host-side port B write enable
ram_q  in  DATA_W  port B read data; synchronous, 1-cycle latency
run_cycles  out  32  run length counter (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, clock clk) values: state IDLE, core_reset=1, ram_sel=1, ram_w=0, busy=0, done_flag=0, host_rvalid=0, host_rdata=0, run_cycles=0.
- Reset mid-operation: a partial write is discarded with no RAM write, a partial read is dropped, and a running core is re-held in reset.
- States: IDLE, WR_COLLECT, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND, RUN, FIN.
- host_ready = (IDLE && !host_start) || WR_COLLECT.
- IDLE: host_start=1 takes priority over host_valid in the same cycle; it clears done_flag and goes to RUN.
- IDLE write: an accepted beat with host_we=1 latches the address, stores beat 0 and goes to WR_COLLECT, beat count = 1.
- IDLE read: an accepted beat with host_we=0 latches the address and goes to RD_ADDR; its wdata is ignored.
- WR_COLLECT: each accepted beat is stored little-endian (beat k goes to bits [k*HOST_W +: HOST_W]); host_we and host_addr are ignored.
  - Bits beyond DATA_W on the last beat are dropped.
  - Gaps with host_valid=0 are allowed.
  - After beat BEATS-1 is accepted, go to WR_COMMIT.
- WR_COMMIT (one cycle): ram_w=1, ram_addr=latched address, ram_wdata=assembled word; then IDLE.
- RD_ADDR: drive ram_addr, then RD_WAIT.
- RD_WAIT: capture ram_q into the shift register, then RD_SEND.
- RD_SEND: host_rvalid=1 for exactly BEATS consecutive cycles (no backpressure).
  - host_rdata = low HOST_W bits, then shift right by HOST_W each cycle.
  - Upper bits of the last beat are zero.
  - Then IDLE.
- host_start outside IDLE is ignored. host_ready=0 blocks host beats outside IDLE/WR_COLLECT.
- RUN: core_reset=0, ram_sel=0, ram_w=0, busy=1. core_done=1 goes to FIN.
- FIN (one cycle): core_reset=1, ram_sel=1, busy=0, done_flag set; then IDLE.
- core_reset is 1 in every state except RUN, so the core restarts at microcode address 0 on each run.
- ram_sel=1 in all states except RUN. ram_sel switches only on a state change, so host and core never drive port B in the same cycle.
- A stale core_done outside RUN is ignored.

Optional Feature:
PAIRING_RUN_CNT_EN
- Defined: run_cycles clears on accepted host_start, increments every RUN cycle, saturates at 32'hFFFFFFFF, and holds after FIN.
- Undefined: run_cycles is constant 0 and no counter logic is present.

Test Plan:
- Write addr 5, beats 0x11111111..0x77777777 with idle gaps -> single ram_w pulse at addr 5, ram_wdata[193:192]=2'b11, host_ready=0 during WR_COMMIT.
- Preload ram_q=all-ones at addr 9, read addr 9 -> host_rvalid for 7 consecutive cycles starting 3 cycles after acceptance; beats 0-5 = 0xFFFFFFFF, beat 6 = 0x00000003.
- host_start with host_valid in the same cycle -> RUN entered, beat not accepted. core_done after 100 RUN cycles -> FIN, done_flag=1, core_reset=1; run_cycles=100 with PAIRING_RUN_CNT_EN.
- host_start during RD_SEND and host_valid during RUN -> both ignored, host_ready=0, no ram_w.
- reset after 3 write beats -> no ram_w ever; next full write to addr 0 assembles only new beats.
- Second run -> done_flag clears on start, busy=1, ram_sel=0 throughout RUN.

Source files
------------

// File: rtl/pairing_host_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pairing_host_ctrl_if : 32-bit beat-serial host bus of the pairing run ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pairing_host_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int HOST_W = 32
);
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [HOST_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [HOST_W-1:0] host_rdata;
  logic              host_start;

  modport master (
    output host_valid, host_we, host_addr, host_wdata, host_start,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata, host_start,
    output host_ready, host_rvalid, host_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pairing_host_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pairing_host_ctrl : host load/run/readback controller for the GF(3^m) core.
// Optional run-length counter enabled by macro PAIRING_RUN_CNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pairing_host_ctrl #(
  parameter int DATA_W = 194,
  parameter int ADDR_W = 6,
  parameter int HOST_W = 32,
  parameter int BEATS  = 7   // must equal ceil(DATA_W/HOST_W)
) (
  input  logic              clk,
  input  logic              reset,
  pairing_host_ctrl_if.slave host,
  output logic              busy,
  output logic              done_flag,
  output logic              core_reset,
  input  logic              core_done,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_q,
  output logic [31:0]       run_cycles
);

  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int DI_W   = $clog2(DATA_W);
  localparam int HI_W   = $clog2(HOST_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_COMMIT  = 3'd2,
    RD_ADDR    = 3'd3,
    RD_WAIT    = 3'd4,
    RD_SEND    = 3'd5,
    RUN        = 3'd6,
    FIN        = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                done_q, done_d;

  // Places one host beat little-endian into the word; bits past DATA_W fall away.
  function automatic logic [DATA_W-1:0] put_beat(
    input logic [DATA_W-1:0] cur,
    input logic [BEAT_W-1:0] idx,
    input logic [HOST_W-1:0] beat
  );
    logic [DATA_W-1:0] r;
    r = cur;
    for (int i = 0; i < DATA_W; i++) begin
      if (i / HOST_W == int'(idx)) begin
        r[DI_W'(i)] = beat[HI_W'(i % HOST_W)];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    addr_d           = addr_q;
    wbuf_d           = wbuf_q;
    shift_d          = shift_q;
    done_d           = done_q;
    host.host_ready  = 1'b0;
    host.host_rvalid = 1'b0;
    host.host_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        host.host_ready = !host.host_start;
        if (host.host_start) begin
          done_d  = 1'b0;
          state_d = RUN;
        end else if (host.host_valid) begin
          addr_d = host.host_addr;
          if (host.host_we) begin
            wbuf_d  = put_beat(wbuf_q, '0, host.host_wdata);
            beat_d  = BEAT_W'(1);
            state_d = WR_COLLECT;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_COLLECT: begin
        host.host_ready = 1'b1;
        if (host.host_valid) begin
          wbuf_d = put_beat(wbuf_q, beat_q, host.host_wdata);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = WR_COMMIT;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      WR_COMMIT: state_d = IDLE;
      RD_ADDR:   state_d = RD_WAIT;
      RD_WAIT: begin
        shift_d = ram_q;
        state_d = RD_SEND;
      end
      RD_SEND: begin
        host.host_rvalid = 1'b1;
        host.host_rdata  = shift_q[HOST_W-1:0];
        shift_d          = shift_q >> HOST_W;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RUN: begin
        if (core_done) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Port B ownership and core reset follow the registered state only, so the
  // hand-over between host and core always lands on a clock edge.
  assign busy       = (state_q == RUN);
  assign core_reset = (state_q != RUN);
  assign ram_sel    = (state_q != RUN);
  assign ram_w      = (state_q == WR_COMMIT);
  assign ram_addr   = addr_q;
  assign ram_wdata  = wbuf_q;
  assign done_flag  = done_q;

`ifdef PAIRING_RUN_CNT_EN
  logic [31:0] run_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= '0;
    end else if (state_q == IDLE && host.host_start) begin
      run_cnt_q <= '0;
    end else if (state_q == RUN && run_cnt_q != 32'hFFFF_FFFF) begin
      run_cnt_q <= run_cnt_q + 32'd1;
    end
  end

  assign run_cycles = run_cnt_q;
`else
  assign run_cycles = '0;
`endif

endmodule
`default_nettype wire
